// File: rtl/lsu_pkg.sv
// Shared types, constants and decode helpers for the load/store unit.
// Optional LSU_MISALIGN_CHECK_EN enables error reporting of bad accesses.
package lsu_pkg;

    localparam int WMASK_W = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Anything not a byte or halfword encoding falls back to word size
    function automatic size_e dec_size(
        input logic       store,
        input logic [2:0] f3
    );
        size_e sz;
        sz = SZ_W;
        if (f3 == F3_B || (!store && f3 == F3_BU))
            sz = SZ_B;
        else if (f3 == F3_H || (!store && f3 == F3_HU))
            sz = SZ_H;
        return sz;
    endfunction

    function automatic logic req_bad(
        input logic       store,
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        logic  unsup;
        size_e sz;
        sz = dec_size(store, f3);
        if (store)
            unsup = (f3 > F3_W);
        else
            unsup = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        return unsup
            || (sz == SZ_H && lane[0])
            || (sz == SZ_W && lane != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
// The slave modport is the lsu side, master is the core/memory side.
interface lsu_if;
    import lsu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_store;
    logic [2:0]          in_funct3;
    logic [31:0]         in_addr;
    logic [31:0]         in_wdata;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_rdata;
    logic                out_err;
    logic                ren;
    logic                wen;
    logic [WMASK_W-1:0]  wmask;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [31:0]         data;
    logic                sram_valid;

    modport slave (
        input  in_valid, in_store, in_funct3,
        input  in_addr, in_wdata, out_ready,
        input  data, sram_valid,
        output in_ready, out_valid, out_rdata,
        output out_err, ren, wen, wmask,
        output addr, wdata
    );

    modport master (
        output in_valid, in_store, in_funct3,
        output in_addr, in_wdata, out_ready,
        output data, sram_valid,
        input  in_ready, out_valid, out_rdata,
        input  out_err, ren, wen, wmask,
        input  addr, wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Lane steering: store byte mask/shift and load extract with extension.
// Misaligned halfword/word accesses are truncated to their aligned lane.
module lsu_align
    import lsu_pkg::*;
(
    input  logic               store,
    input  logic [2:0]         funct3,
    input  logic [1:0]         lane,
    input  logic [31:0]        st_data,
    input  logic [31:0]        ld_word,
    output logic [WMASK_W-1:0] st_mask,
    output logic [31:0]        st_wdata,
    output logic [31:0]        ld_data
);

    size_e       sz;
    logic        sx;
    logic [31:0] sh_b;
    logic [31:0] sh_h;

    assign sz   = dec_size(store, funct3);
    assign sx   = ~funct3[2];
    assign sh_b = ld_word >> {lane, 3'b000};
    assign sh_h = ld_word >> {lane[1], 4'b0000};

    always_comb begin
        st_mask  = 8'h0F;
        st_wdata = st_data;
        ld_data  = ld_word;
        unique case (sz)
            SZ_B: begin
                st_mask  = 8'(4'b0001 << lane);
                st_wdata = st_data << {lane, 3'b000};
                ld_data  = {{24{sx & sh_b[7]}}, sh_b[7:0]};
            end
            SZ_H: begin
                st_mask  = lane[1] ? 8'h0C : 8'h03;
                st_wdata = st_data << {lane[1], 4'b0000};
                ld_data  = {{16{sx & sh_h[15]}}, sh_h[15:0]};
            end
            default: begin
                st_mask  = 8'h0F;
                st_wdata = st_data;
                ld_data  = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM driving the single-port sram handshake.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned/unsupported requests.
module lsu
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    logic [2:0]         state;
    logic               st_q;
    logic [2:0]         f3_q;
    logic [31:0]        addr_q;
    logic [31:0]        wd_q;
    logic [31:0]        rdata_q;
    logic [WMASK_W-1:0] st_mask;
    logic [31:0]        st_wdata;
    logic [31:0]        ld_data;

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    logic bad;
    assign bad = req_bad(bus.in_store, bus.in_funct3,
                         bus.in_addr[1:0]);
`endif

    lsu_align u_align (
        .store    (st_q),
        .funct3   (f3_q),
        .lane     (addr_q[1:0]),
        .st_data  (wd_q),
        .ld_word  (bus.data),
        .st_mask  (st_mask),
        .st_wdata (st_wdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        st_q    <= bus.in_store;
                        f3_q    <= bus.in_funct3;
                        addr_q  <= bus.in_addr;
                        wd_q    <= bus.in_wdata;
                        rdata_q <= '0;
                        state   <= bus.in_store ? S_WR : S_RD_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
                        err_q   <= bad;
                        if (bad)
                            state <= S_DONE;
`endif
                    end
                end
                S_RD_REQ: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (bus.sram_valid) begin
                        rdata_q <= ld_data;
                        state   <= S_DONE;
                    end
                end
                S_WR: state <= S_DONE;
                S_DONE: begin
                    if (bus.out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset drops them at once
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.ren       = (state == S_RD_REQ);
    assign bus.wen       = (state == S_WR);
    assign bus.wmask     = bus.wen ? st_mask : '0;
    assign bus.wdata     = bus.wen ? st_wdata : '0;
    assign bus.addr      = {addr_q[31:2], 2'b00};
    assign bus.out_rdata = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
    assign bus.out_err   = err_q;
`else
    assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: random loads/stores against a lane model.
// Build with LSU_MISALIGN_CHECK_EN to also cover the error path.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if bus ();

    lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          hold   = 0;
    logic        pend   = 1'b0;
    logic [31:0] last_rd;
    exp_t        e;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_load(
        input logic [2:0] f3, input logic [1:0] a,
        input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [7:0] ref_mask(
        input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 8'(1 << a);
            3'b001:  return a[1] ? 8'h0C : 8'h03;
            default: return 8'h0F;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(
        input logic [2:0] f3, input logic [1:0] a,
        input logic [31:0] wd);
        case (f3)
            3'b000:  return wd << (8 * int'(a));
            3'b001:  return wd << (16 * int'(a[1]));
            default: return wd;
        endcase
    endfunction

    function automatic logic ref_err(
        input logic st, input logic [2:0] f3,
        input logic [1:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        logic half;
        logic word;
        half = st ? (f3 == 3'b001)
                  : (f3 == 3'b001 || f3 == 3'b101);
        word = st ? (f3 == 3'b010)
                  : (f3 == 3'b010);
        if (st && f3 > 3'b010) return 1'b1;
        if (!st && (f3 == 3'b011 || f3 >= 3'b110)) return 1'b1;
        if (half && a[0]) return 1'b1;
        if (word && a != 2'b00) return 1'b1;
        return 1'b0;
`else
        return (st & 1'b0) | (f3[0] & 1'b0) | (a[0] & 1'b0);
`endif
    endfunction

    // Monitor: owns out_ready, pops the scoreboard on each handshake
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                bus.out_ready = 1'b0;
            end else begin
                if (pend && bus.out_valid)
                    check("rdata_stable", bus.out_rdata, last_rd);
                if (hold > 0) begin
                    hold--;
                    bus.out_ready = 1'b0;
                end else begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
                if (bus.out_valid) begin
                    check("busy_ready", 32'(bus.in_ready), 0);
                    if (bus.out_ready) begin
                        pend = 1'b0;
                        if (sb.size() == 0) begin
                            check("unexpected_out", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("out_rdata", bus.out_rdata, e.rdata);
                            check("out_err", 32'(bus.out_err),
                                  32'(e.err));
                        end
                    end else begin
                        pend = 1'b1;
                        last_rd = bus.out_rdata;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] ad,
                          input logic [31:0] wd,
                          input logic [31:0] word,
                          input int dly, input int hold_n);
        logic        bad;
        logic [31:0] waddr;
        exp_t        x;
        wait_idle();
        hold  = hold_n;
        bad   = ref_err(st, f3, ad[1:0]);
        waddr = ad & 32'hFFFF_FFFC;
        x.err   = bad;
        x.rdata = (bad || st) ? 32'h0
                : ref_load(f3, ad[1:0], word);
        sb.push_back(x);
        bus.in_valid  = 1'b1;
        bus.in_store  = st;
        bus.in_funct3 = f3;
        bus.in_addr   = ad;
        bus.in_wdata  = wd;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_addr   = $urandom;
        check("ready_low", 32'(bus.in_ready), 0);
        if (bad) begin
            check("err_ren", 32'(bus.ren), 0);
            check("err_wen", 32'(bus.wen), 0);
            check("err_done", 32'(bus.out_valid), 1);
        end else if (st) begin
            check("wen", 32'(bus.wen), 1);
            check("wr_ren", 32'(bus.ren), 0);
            check("wmask", 32'(bus.wmask), 32'(ref_mask(f3, ad[1:0])));
            check("wdata", bus.wdata, ref_wdata(f3, ad[1:0], wd));
            check("wr_addr", bus.addr, waddr);
            bus.sram_valid = 1'b1;
            @(negedge clk);
            bus.sram_valid = 1'b0;
            check("st_done", 32'(bus.out_valid), 1);
            check("wen_drop", 32'(bus.wen), 0);
            check("wmask_idle", 32'(bus.wmask), 0);
            check("wdata_idle", bus.wdata, 0);
        end else begin
            check("ren", 32'(bus.ren), 1);
            check("rd_wen", 32'(bus.wen), 0);
            check("rd_addr", bus.addr, waddr);
            check("rd_wmask", 32'(bus.wmask), 0);
            // A response during RD_REQ must be ignored
            bus.sram_valid = 1'($urandom_range(0, 1));
            bus.data = $urandom;
            @(negedge clk);
            check("ren_once", 32'(bus.ren), 0);
            check("ld_early", 32'(bus.out_valid), 0);
            bus.sram_valid = 1'b0;
            for (int i = 0; i < dly; i++) begin
                bus.data = $urandom;
                @(negedge clk);
                check("ren_wait", 32'(bus.ren), 0);
                check("addr_held", bus.addr, waddr);
            end
            bus.sram_valid = 1'b1;
            bus.data = word;
            @(negedge clk);
            bus.sram_valid = 1'b0;
            bus.data = $urandom;
            check("ld_done", 32'(bus.out_valid), 1);
        end
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] ad;
        int          n;
        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_store   = 1'b0;
        bus.in_funct3  = 3'b000;
        bus.in_addr    = '0;
        bus.in_wdata   = '0;
        bus.data       = '0;
        bus.sram_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_rdata", bus.out_rdata, 0);
        check("rst_err", 32'(bus.out_err), 0);
        check("rst_ren", 32'(bus.ren), 0);
        check("rst_wen", 32'(bus.wen), 0);
        check("rst_wmask", 32'(bus.wmask), 0);
        check("rst_addr", bus.addr, 0);
        check("rst_wdata", bus.wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, F3_B, 32'h8000_0003, 0, 32'h8011_2233, 0, 0);
        do_req(1'b0, F3_HU, 32'h8000_0002, 0, 32'hBEEF_1234, 0, 0);
        do_req(1'b1, F3_B, 32'h8000_0001, 32'hAB, 0, 0, 0);
        do_req(1'b0, F3_W, 32'h8000_0010, 0, 32'hCAFE_F00D, 3, 8);
`ifdef LSU_MISALIGN_CHECK_EN
        do_req(1'b0, F3_W, 32'h8000_0002, 0, 32'h1234_5678, 0, 0);
`endif

        for (int k = 0; k < 300; k++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            ad = $urandom;
            if (st && f3 == F3_H) ad[0] = 1'b0;
            if (st && f3 != F3_B) ad[1:0] = 2'b00;
            do_req(st, f3, ad, $urandom, $urandom,
                   $urandom_range(0, 3), 0);
        end

        wait_idle();
        bus.in_valid  = 1'b1;
        bus.in_store  = 1'b0;
        bus.in_funct3 = F3_W;
        bus.in_addr   = 32'h8000_0040;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ren", 32'(bus.ren), 0);
        check("mid_rst_wen", 32'(bus.wen), 0);
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 1);
        check("post_rst_valid", 32'(bus.out_valid), 0);
        do_req(1'b0, F3_H, 32'h8000_0006, 0, 32'h8001_7FFF, 1, 0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator end of the single-port data-memory `sram` handshake (`ren`/`wen`/`wmask`/`addr`/`wdata` → `data`/`sram_valid`). It sits between the execute stage and data memory. It accepts one load or store per request through valid/ready, and issues the word-aligned memory access with the correct byte mask. Load data is returned lane-extracted and sign- or zero-extended.

## Interface
- No parameters.
- Reset is asynchronous and active-high; one clock.
- `clk` in 1: sole clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `in_store` in 1: 1 = store, 0 = load.
- `in_funct3` in 3: RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `in_addr` in 32: byte address.
- `in_wdata` in 32: store data, right-aligned.
- `out_valid` out 1: result/completion present.
- `out_ready` in 1: consumer accepts result.
- `out_rdata` out 32: extended load data; 0 for stores.
- `out_err` out 1: misaligned/unsupported access (only with `LSU_MISALIGN_CHECK_EN`, else tied 0).
- `ren` out 1: memory read request.
- `wen` out 1: memory write request.
- `wmask` out 8: byte-lane write mask; bits [7:4] always 0.
- `addr` out 32: word-aligned address, `{in_addr[31:2],2'b00}`.
- `wdata` out 32: lane-shifted store data.
- `data` in 32: memory read word.
- `sram_valid` in 1: memory response.

## Operation
States: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch store/funct3/addr/wdata.
  - Go to WR if store, else RD_REQ.
- **RD_REQ**
  - `ren`=1 for exactly this one cycle; `addr` driven.
  - Always go to RD_WAIT.
  - `ren` must never be held two consecutive cycles, because memory treats a held `ren` as a new request.
- **RD_WAIT**
  - `ren`=0, `addr` held.
  - On `sram_valid`, extract the lane selected by latched addr[1:0]:
    - byte lane = data[8*a+7:8*a];
    - half lane = data[16*a[1]+15:16*a[1]].
  - Extend: sign for LB/LH, zero for LBU/LHU; LW passes through.
  - Register the result into `out_rdata` and go to DONE.
  - Otherwise stay in RD_WAIT; no timeout.
- **WR**
  - `wen`=1 for exactly one cycle.
  - Mask: SB = 1<<a; SH = 3<<(2*a[1]); SW = 0xF.
  - `wdata` = store data shifted left by 8*a.
  - `sram_valid` is expected in the same cycle. Go to DONE regardless.
- **DONE**
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
  - `out_rdata` and `out_err` are stable while waiting.
- Unsupported funct3 (011, 11x, store 1xx) is decoded as word size.
- `wmask`=0 and `wdata`=0 in every state except WR.

## Timing
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0; `out_rdata`=0; `out_err`=0; `ren`=0; `wen`=0; `wmask`=0; `addr`=0; `wdata`=0.
- Reset asserted mid-operation returns to IDLE immediately. Any in-flight `ren`/`wen` drops in the same cycle and the result is discarded.
- Load latency: accept at cycle 0, `ren` at 1, `sram_valid` at 2 (nominal), `out_valid` at 3.
- Store latency: accept at 0, `wen` at 1, `out_valid` at 2.
- One request in flight. `in_ready`=0 in all states but IDLE, so no simultaneous accept and complete.
- Back-to-back peak: one load per 4 cycles, one store per 3 cycles.
- `sram_valid` outside RD_WAIT/WR is ignored.

## Configuration
`LSU_MISALIGN_CHECK_EN`:
- **Defined:** the following requests are detected in IDLE and go directly to DONE with `out_err`=1, `out_rdata`=0, and no `ren`/`wen` issued:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - unsupported funct3.
- **Undefined:** no check. `out_err` is tied 0. Misaligned halfword/word accesses use the aligned lane (address low bits are truncated by the lane select).

## Structure
- **Package `lsu_pkg`:**
  - state enum;
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - `WMASK_W`=8.
- **Sub-module `lsu_align`:** combinational.
  - Store path: store mask/shift.
  - Load path: lane extract and sign/zero extend.
  - Instantiated once by `lsu`; the FSM stays in `lsu`.

## Test plan
- **LB sign extension:** LB at addr 0x8000_0003, `data`=0x80_11_22_33 → `ren` pulse 1 cycle, `addr`=0x8000_0000, `out_rdata`=0xFFFF_FF80, `out_valid` at cycle 3.
- **LHU zero extension:** LHU at 0x8000_0002, `data`=0xBEEF_1234 → `out_rdata`=0x0000_BEEF.
- **SB lane placement:** SB at 0x8000_0001, `in_wdata`=0x0000_00AB → `wen` 1 cycle, `wmask`=0x02, `wdata`=0x0000_AB00, `out_valid` at cycle 2, `out_rdata`=0.
- **Delayed response and backpressure:** LW where `sram_valid` arrives 3 cycles late; hold `out_ready`=0 for 2 cycles → `ren` not re-pulsed, `out_rdata` stable, `in_ready`=0 until the handshake completes.
- **Reset during RD_WAIT:** assert `rst` → `ren`/`wen`/`out_valid`=0 immediately, `in_ready`=1 after release.
- **Misaligned word (with `LSU_MISALIGN_CHECK_EN`):** LW at 0x8000_0002 → no `ren`, `out_err`=1, `out_rdata`=0.
